// File: rtl/apple_spawner.sv
// Apple placement for the snake game: holds the committed apple cell, hunts for a free
// replacement cell with an LFSR + occupancy handshake, and draws the apple square.
module apple_spawner #(
  parameter int          BIT     = 10,
  parameter int          CELL    = 20,
  parameter int          GRID_W  = 32,
  parameter int          GRID_H  = 24,
  parameter int          INSET   = 2,
  parameter logic [2:0]  COLOR   = 3'b100,
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter int          INIT_GX = 10,
  parameter int          INIT_GY = 12,
  localparam int         GXB     = (GRID_W > 1) ? $clog2(GRID_W) : 1,
  localparam int         GYB     = (GRID_H > 1) ? $clog2(GRID_H) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           frame_tick,
  input  logic           eaten,
  input  logic [BIT-1:0] x_pos,
  input  logic [BIT-1:0] y_pos,
  output logic           check_req,
  output logic [GXB-1:0] cand_gx,
  output logic [GYB-1:0] cand_gy,
  input  logic           check_ack,
  input  logic           check_hit,
  output logic [GXB-1:0] apple_gx,
  output logic [GYB-1:0] apple_gy,
  output logic           apple_valid,
  output logic           apple_active,
  output logic [2:0]     rgb,
  output logic [7:0]     spawn_count
);

  typedef enum logic [1:0] {SHOW, GEN, CHECK, ARM} state_t;

  localparam int         AW     = BIT + 1;
  localparam logic [8:0] GW9    = 9'(GRID_W);
  localparam logic [8:0] GH9    = 9'(GRID_H);
  localparam logic [AW-1:0] CELL_W = AW'(CELL);
  localparam logic [AW-1:0] INS_LO = AW'(INSET);
  localparam logic [AW-1:0] INS_HI = AW'(CELL - INSET);

  state_t         state_q;
  logic [15:0]    lfsr_q, lfsr_d;
  logic [GXB-1:0] cand_gx_q, apple_gx_q, rx;
  logic [GYB-1:0] cand_gy_q, apple_gy_q, ry;
  logic           check_req_q, apple_valid_q, apple_active_q;
  logic [7:0]     spawn_count_q;
  logic           cand_ok;
  logic [AW-1:0]  ax, ay, px, py;
  logic           in_x, in_y;

  // Galois form, shifting right; runs every cycle so the retry sequence never stalls.
  assign lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign rx      = lfsr_q[GXB-1:0];
  assign ry      = lfsr_q[GXB+GYB-1:GXB];
  assign cand_ok = ({{(9-GXB){1'b0}}, rx} < GW9) && ({{(9-GYB){1'b0}}, ry} < GH9);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= SHOW;
      lfsr_q        <= SEED;
      apple_gx_q    <= GXB'(INIT_GX);
      apple_gy_q    <= GYB'(INIT_GY);
      apple_valid_q <= 1'b1;
      check_req_q   <= 1'b0;
      cand_gx_q     <= '0;
      cand_gy_q     <= '0;
      spawn_count_q <= 8'd0;
    end else begin
      lfsr_q <= lfsr_d;
      case (state_q)
        SHOW: if (eaten) begin
          apple_valid_q <= 1'b0;
          state_q       <= GEN;
        end
        GEN: if (cand_ok) begin
          cand_gx_q   <= rx;
          cand_gy_q   <= ry;
          check_req_q <= 1'b1;
          state_q     <= CHECK;
        end
        CHECK: if (check_ack) begin
          check_req_q <= 1'b0;
          state_q     <= check_hit ? GEN : ARM;
        end
        // Commit only at vertical blank so the apple never moves mid-frame.
        ARM: if (frame_tick) begin
          apple_gx_q    <= cand_gx_q;
          apple_gy_q    <= cand_gy_q;
          apple_valid_q <= 1'b1;
          spawn_count_q <= spawn_count_q + 8'd1;
          state_q       <= SHOW;
        end
        default: state_q <= SHOW;
      endcase
    end
  end

  assign ax   = {{(AW-GXB){1'b0}}, apple_gx_q} * CELL_W;
  assign ay   = {{(AW-GYB){1'b0}}, apple_gy_q} * CELL_W;
  assign px   = {1'b0, x_pos};
  assign py   = {1'b0, y_pos};
  assign in_x = (px >= ax + INS_LO) && (px < ax + INS_HI);
  assign in_y = (py >= ay + INS_LO) && (py < ay + INS_HI);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      apple_active_q <= 1'b0;
    end else begin
      apple_active_q <= apple_valid_q && in_x && in_y;
    end
  end

  assign check_req    = check_req_q;
  assign cand_gx      = cand_gx_q;
  assign cand_gy      = cand_gy_q;
  assign apple_gx     = apple_gx_q;
  assign apple_gy     = apple_gy_q;
  assign apple_valid  = apple_valid_q;
  assign apple_active = apple_active_q;
  assign rgb          = COLOR;
  assign spawn_count  = spawn_count_q;

endmodule

// File: tb/tb_apple_spawner.sv
// Bench for apple_spawner: default 32x24 build for directed scenarios, plus a 20x15 build
// exercised with 1000 randomly acknowledged respawns.
module tb_apple_spawner;

  localparam int CELL  = 20;
  localparam int INSET = 2;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       frame_tick = 1'b0, eaten = 1'b0, check_ack = 1'b0, check_hit = 1'b0;
  logic [9:0] x_pos = '0, y_pos = '0;
  logic       check_req, apple_valid, apple_active;
  logic [4:0] cand_gx, cand_gy, apple_gx, apple_gy;
  logic [2:0] rgb;
  logic [7:0] spawn_count;

  logic       s_frame_tick = 1'b0, s_eaten = 1'b0, s_check_ack = 1'b0, s_check_hit = 1'b0;
  logic       s_check_req, s_apple_valid, s_apple_active;
  logic [4:0] s_cand_gx, s_apple_gx;
  logic [3:0] s_cand_gy, s_apple_gy;
  logic [2:0] s_rgb;
  logic [7:0] s_spawn_count;

  int          checks = 0, failures = 0;
  int          cand_q[$], s_cand_q[$];
  int          last_cand = 0, s_last_cand = 0;
  logic        req_prev = 1'b0, s_req_prev = 1'b0;
  logic [15:0] m_lfsr;

  apple_spawner u_dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .eaten(eaten),
    .x_pos(x_pos), .y_pos(y_pos), .check_req(check_req), .cand_gx(cand_gx),
    .cand_gy(cand_gy), .check_ack(check_ack), .check_hit(check_hit),
    .apple_gx(apple_gx), .apple_gy(apple_gy), .apple_valid(apple_valid),
    .apple_active(apple_active), .rgb(rgb), .spawn_count(spawn_count)
  );

  apple_spawner #(.GRID_W(20), .GRID_H(15)) u_small (
    .clk(clk), .rst_n(rst_n), .frame_tick(s_frame_tick), .eaten(s_eaten),
    .x_pos(x_pos), .y_pos(y_pos), .check_req(s_check_req), .cand_gx(s_cand_gx),
    .cand_gy(s_cand_gy), .check_ack(s_check_ack), .check_hit(s_check_hit),
    .apple_gx(s_apple_gx), .apple_gy(s_apple_gy), .apple_valid(s_apple_valid),
    .apple_active(s_apple_active), .rgb(s_rgb), .spawn_count(s_spawn_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // First in-range candidate starting from the LFSR value seen on GEN entry; packed gy<<8|gx.
  function automatic int pred_cand(input logic [15:0] start, input int gw, input int gh,
                                   input int gxb, input int gyb);
    logic [15:0] v;
    int rx, ry;
    v = start;
    for (int n = 0; n < 70000; n++) begin
      rx = int'(v) & ((1 << gxb) - 1);
      ry = (int'(v) >> gxb) & ((1 << gyb) - 1);
      if (rx < gw && ry < gh) return (ry << 8) | rx;
      v = lfsr_step(v);
    end
    return -1;
  endfunction

  function automatic logic pix_exp(input int gx, input int gy, input logic v,
                                   input int x, input int y);
    int ax, ay;
    ax = gx * CELL;
    ay = gy * CELL;
    return v && (x >= ax + INSET) && (x < ax + CELL - INSET) &&
           (y >= ay + INSET) && (y < ay + CELL - INSET);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= lfsr_step(m_lfsr);
  end

  // Candidate scoreboard for the default build: pop on each check_req rise, hold-stable after.
  always @(negedge clk) begin : mon_main
    int got, exp;
    got = (int'(cand_gy) << 8) | int'(cand_gx);
    if (rst_n && check_req && !req_prev) begin
      checks++;
      if (cand_q.size() == 0) begin
        failures++;
        $display("FAIL cand_unexpected got=%h expected none", got);
      end else begin
        exp = cand_q.pop_front();
        if (got !== exp) begin
          failures++;
          $display("FAIL cand_value got=%h expected=%h", got, exp);
        end
      end
      checks++;
      if (int'(cand_gx) >= 32 || int'(cand_gy) >= 24) begin
        failures++;
        $display("FAIL cand_range got gx=%0d gy=%0d expected <32,<24", cand_gx, cand_gy);
      end
      last_cand = got;
      $display("cand gx=%0d gy=%0d", cand_gx, cand_gy);
    end else if (check_req && req_prev) begin
      checks++;
      if (got !== last_cand) begin
        failures++;
        $display("FAIL cand_stable got=%h expected=%h", got, last_cand);
      end
    end
    req_prev = check_req;
  end

  always @(negedge clk) begin : mon_small
    int got, exp;
    got = (int'(s_cand_gy) << 8) | int'(s_cand_gx);
    if (rst_n && s_check_req && !s_req_prev) begin
      checks++;
      if (s_cand_q.size() == 0) begin
        failures++;
        $display("FAIL s_cand_unexpected got=%h expected none", got);
      end else begin
        exp = s_cand_q.pop_front();
        if (got !== exp) begin
          failures++;
          $display("FAIL s_cand_value got=%h expected=%h", got, exp);
        end
      end
      checks++;
      if (int'(s_cand_gx) >= 20 || int'(s_cand_gy) >= 15) begin
        failures++;
        $display("FAIL s_cand_range got gx=%0d gy=%0d expected <20,<15", s_cand_gx, s_cand_gy);
      end
      s_last_cand = got;
    end else if (s_check_req && s_req_prev) begin
      checks++;
      if (got !== s_last_cand) begin
        failures++;
        $display("FAIL s_cand_stable got=%h expected=%h", got, s_last_cand);
      end
    end
    s_req_prev = s_check_req;
  end

  task automatic pulse_eat();
    eaten = 1'b1;
    @(negedge clk);
    eaten = 1'b0;
    cand_q.push_back(pred_cand(m_lfsr, 32, 24, 5, 5));
  endtask

  task automatic ack(input logic hit);
    check_ack = 1'b1;
    check_hit = hit;
    @(negedge clk);
    check_ack = 1'b0;
    check_hit = 1'b0;
    if (hit) cand_q.push_back(pred_cand(m_lfsr, 32, 24, 5, 5));
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (check_req) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    int px[10] = '{200, 201, 219, 222, 202, 217, 218, 210, 210, 210};
    int py[10] = '{240, 240, 240, 242, 242, 257, 250, 258, 241, 250};
    logic e;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({apple_valid, apple_gx, apple_gy, check_req, spawn_count, apple_active} !==
        {1'b1, 5'd10, 5'd12, 1'b0, 8'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state got v=%b gx=%0d gy=%0d req=%b cnt=%0d act=%b expected 1/10/12/0/0/0",
               apple_valid, apple_gx, apple_gy, check_req, spawn_count, apple_active);
    end
    checks++;
    if ({cand_gx, cand_gy, rgb} !== {5'd0, 5'd0, 3'b100}) begin
      failures++;
      $display("FAIL reset_cand_rgb got gx=%0d gy=%0d rgb=%b expected 0/0/100", cand_gx, cand_gy, rgb);
    end
    for (int i = 0; i < 10; i++) begin
      x_pos = 10'(px[i]);
      y_pos = 10'(py[i]);
      e = pix_exp(10, 12, 1'b1, px[i], py[i]);
      @(negedge clk);
      checks++;
      if (apple_active !== e) begin
        failures++;
        $display("FAIL pixel (%0d,%0d) got=%b expected=%b", px[i], py[i], apple_active, e);
      end
      $display("pixel (%0d,%0d) active=%b", px[i], py[i], apple_active);
    end
  endtask

  task automatic test_eaten();
    bit ok;
    pulse_eat();
    checks++;
    if (apple_valid !== 1'b0) begin
      failures++;
      $display("FAIL eaten_valid got=%b expected=0", apple_valid);
    end
    for (int i = 0; i < 4; i++) begin
      x_pos = 10'(202 + 5 * i);
      y_pos = 10'(243 + 4 * i);
      @(negedge clk);
      checks++;
      if (apple_active !== 1'b0) begin
        failures++;
        $display("FAIL eaten_pixel x=%0d got=%b expected=0", x_pos, apple_active);
      end
    end
    wait_req(ok);
    checks++;
    if (ok !== 1'b1) begin
      failures++;
      $display("FAIL eaten_req_timeout got=0 expected=1");
    end
  endtask

  task automatic test_retries();
    bit ok;
    repeat (50) @(negedge clk);
    checks++;
    if (check_req !== 1'b1) begin
      failures++;
      $display("FAIL hold_req got=%b expected=1", check_req);
    end
    for (int k = 0; k < 3; k++) begin
      ack(1'b1);
      checks++;
      if (check_req !== 1'b0) begin
        failures++;
        $display("FAIL hit_drop_req got=%b expected=0", check_req);
      end
      wait_req(ok);
      checks++;
      if (ok !== 1'b1) begin
        failures++;
        $display("FAIL retry_req_timeout attempt=%0d got=0 expected=1", k);
      end
    end
    ack(1'b0);
    repeat (10) @(negedge clk);
    checks++;
    if ({check_req, apple_valid, spawn_count, apple_gx} !== {1'b0, 1'b0, 8'd0, 5'd10}) begin
      failures++;
      $display("FAIL armed_no_commit got req=%b v=%b cnt=%0d gx=%0d expected 0/0/0/10",
               check_req, apple_valid, spawn_count, apple_gx);
    end
    pulse_tick();
    checks++;
    if ({int'(apple_gy) << 8 | int'(apple_gx), apple_valid, spawn_count} !==
        {last_cand, 1'b1, 8'd1}) begin
      failures++;
      $display("FAIL commit1 got pos=%h v=%b cnt=%0d expected pos=%h v=1 cnt=1",
               (int'(apple_gy) << 8) | int'(apple_gx), apple_valid, spawn_count, last_cand);
    end
    $display("commit gx=%0d gy=%0d count=%0d", apple_gx, apple_gy, spawn_count);
  endtask

  task automatic test_tick_with_ack();
    bit ok;
    pulse_eat();
    wait_req(ok);
    checks++;
    if (ok !== 1'b1) begin
      failures++;
      $display("FAIL tick_ack_req_timeout got=0 expected=1");
    end
    check_ack  = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    check_ack  = 1'b0;
    frame_tick = 1'b0;
    checks++;
    if ({apple_valid, spawn_count} !== {1'b0, 8'd1}) begin
      failures++;
      $display("FAIL tick_with_ack got v=%b cnt=%0d expected v=0 cnt=1", apple_valid, spawn_count);
    end
    repeat (3) @(negedge clk);
    pulse_tick();
    checks++;
    if ({int'(apple_gy) << 8 | int'(apple_gx), apple_valid, spawn_count} !==
        {last_cand, 1'b1, 8'd2}) begin
      failures++;
      $display("FAIL commit2 got pos=%h v=%b cnt=%0d expected pos=%h v=1 cnt=2",
               (int'(apple_gy) << 8) | int'(apple_gx), apple_valid, spawn_count, last_cand);
    end
    $display("commit gx=%0d gy=%0d count=%0d", apple_gx, apple_gy, spawn_count);
  endtask

  task automatic test_eaten_ignored();
    bit ok;
    frame_tick = 1'b1;
    pulse_eat();
    frame_tick = 1'b0;
    checks++;
    if ({apple_valid, spawn_count} !== {1'b0, 8'd2}) begin
      failures++;
      $display("FAIL eat_tick_show got v=%b cnt=%0d expected v=0 cnt=2", apple_valid, spawn_count);
    end
    wait_req(ok);
    eaten = 1'b1;
    @(negedge clk);
    eaten = 1'b0;
    checks++;
    if (check_req !== 1'b1) begin
      failures++;
      $display("FAIL eat_in_check got req=%b expected=1", check_req);
    end
    ack(1'b1);
    eaten = 1'b1;
    @(negedge clk);
    eaten = 1'b0;
    wait_req(ok);
    checks++;
    if (ok !== 1'b1) begin
      failures++;
      $display("FAIL eat_in_gen_timeout got=0 expected=1");
    end
    ack(1'b0);
    eaten = 1'b1;
    @(negedge clk);
    eaten = 1'b0;
    checks++;
    if ({check_req, apple_valid, spawn_count} !== {1'b0, 1'b0, 8'd2}) begin
      failures++;
      $display("FAIL eat_in_arm got req=%b v=%b cnt=%0d expected 0/0/2", check_req, apple_valid, spawn_count);
    end
    pulse_tick();
    repeat (20) @(negedge clk);
    checks++;
    if ({int'(apple_gy) << 8 | int'(apple_gx), apple_valid, spawn_count, check_req} !==
        {last_cand, 1'b1, 8'd3, 1'b0}) begin
      failures++;
      $display("FAIL commit3 got pos=%h v=%b cnt=%0d req=%b expected pos=%h v=1 cnt=3 req=0",
               (int'(apple_gy) << 8) | int'(apple_gx), apple_valid, spawn_count, check_req, last_cand);
    end
    checks++;
    if (cand_q.size() !== 0) begin
      failures++;
      $display("FAIL leftover_cands got=%0d expected=0", cand_q.size());
    end
    $display("commit gx=%0d gy=%0d count=%0d", apple_gx, apple_gy, spawn_count);
  endtask

  task automatic test_reset_mid();
    bit ok;
    pulse_eat();
    wait_req(ok);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({check_req, apple_gx, apple_gy, apple_valid, spawn_count, cand_gx, cand_gy} !==
        {1'b0, 5'd10, 5'd12, 1'b1, 8'd0, 5'd0, 5'd0}) begin
      failures++;
      $display("FAIL reset_mid got req=%b gx=%0d gy=%0d v=%b cnt=%0d expected 0/10/12/1/0",
               check_req, apple_gx, apple_gy, apple_valid, spawn_count);
    end
    repeat (5) @(negedge clk);
    checks++;
    if ({check_req, apple_valid} !== 2'b01) begin
      failures++;
      $display("FAIL reset_mid_idle got req=%b v=%b expected req=0 v=1", check_req, apple_valid);
    end
    $display("reset mid-search apple gx=%0d gy=%0d", apple_gx, apple_gy);
  endtask

  task automatic test_small_grid();
    logic hit;
    int   c;
    for (int i = 0; i < 1000; i++) begin
      s_eaten = 1'b1;
      @(negedge clk);
      s_eaten = 1'b0;
      s_cand_q.push_back(pred_cand(m_lfsr, 20, 15, 5, 4));
      hit = 1'b1;
      while (hit) begin
        for (c = 0; c < 200 && !s_check_req; c++) @(negedge clk);
        checks++;
        if (s_check_req !== 1'b1) begin
          failures++;
          $display("FAIL s_req_timeout respawn=%0d got=0 expected=1", i);
          return;
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        hit = ($urandom_range(0, 3) == 0);
        s_check_ack = 1'b1;
        s_check_hit = hit;
        @(negedge clk);
        s_check_ack = 1'b0;
        s_check_hit = 1'b0;
        if (hit) s_cand_q.push_back(pred_cand(m_lfsr, 20, 15, 5, 4));
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      s_frame_tick = 1'b1;
      @(negedge clk);
      s_frame_tick = 1'b0;
      checks++;
      if ({int'(s_apple_gy) << 8 | int'(s_apple_gx), s_apple_valid, s_spawn_count} !==
          {s_last_cand, 1'b1, 8'((i + 1) % 256)}) begin
        failures++;
        $display("FAIL s_commit respawn=%0d got pos=%h v=%b cnt=%0d expected pos=%h v=1 cnt=%0d",
                 i, (int'(s_apple_gy) << 8) | int'(s_apple_gx), s_apple_valid, s_spawn_count,
                 s_last_cand, (i + 1) % 256);
      end
      $display("respawn %0d gx=%0d gy=%0d count=%0d", i, s_apple_gx, s_apple_gy, s_spawn_count);
    end
  endtask

  initial begin
    test_reset();
    test_eaten();
    test_retries();
    test_tick_with_ack();
    test_eaten_ignored();
    test_reset_mid();
    test_small_grid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
